// File: rtl/ex_alu_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The slave modport is the execute stage's view; master is the driver's view.
interface ex_alu_stage_if;
  logic        iValid;
  logic [3:0]  iALUctrl;
  logic [31:0] iSrcA;
  logic [31:0] iSrcB;
  logic [4:0]  iShamt;
  logic        iRegWrite;
  logic [4:0]  iRd;
  logic        iBranch;
  logic        iPredTaken;
  logic [31:0] iBrTarget;
  logic [31:0] iPCplus4;
  logic        iFlush;
  logic        iMemStall;
  logic        oStall;
  logic        oValid_M;
  logic [31:0] oResult_M;
  logic [4:0]  oRd_M;
  logic        oRegWrite_M;
  logic        oMispredict;
  logic [31:0] oRedirectPC;
  logic        oBrUpdate;
  logic        oBrTaken;
  logic        oOvfExc;

  modport slave (
    input  iValid, iALUctrl, iSrcA, iSrcB, iShamt, iRegWrite, iRd, iBranch,
           iPredTaken, iBrTarget, iPCplus4, iFlush, iMemStall,
    output oStall, oValid_M, oResult_M, oRd_M, oRegWrite_M, oMispredict,
           oRedirectPC, oBrUpdate, oBrTaken, oOvfExc
  );

  modport master (
    output iValid, iALUctrl, iSrcA, iSrcB, iShamt, iRegWrite, iRd, iBranch,
           iPredTaken, iBrTarget, iPCplus4, iFlush, iMemStall,
    input  oStall, oValid_M, oResult_M, oRd_M, oRegWrite_M, oMispredict,
           oRedirectPC, oBrUpdate, oBrTaken, oOvfExc
  );
endinterface

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: ALU, serial multi-cycle shifter, beq resolution, EX/MEM register.
// Optional feature: define EX_OVF_TRAP_EN to trap signed add/sub overflow (oOvfExc).
module ex_alu_stage #(
  parameter int SHIFT_STEP = 4
) (
  input  logic clk,
  input  logic rst_n,
  ex_alu_stage_if.slave bus
);
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} stateT;
  stateT state, stateNext;

  logic [31:0] acc, accNext, aluRes, emResult;
  logic [4:0]  rem, stepAmt, emRd;
  logic        isShift, longStart, shiftMore, trap;
  logic        emLoad, emValid, emRegWrite;
  logic        brFire, brTaken;

  function automatic logic [31:0] shiftOp(input logic [3:0] op, input logic [31:0] val,
                                          input logic [4:0] amt);
    logic [31:0] r;
    case (op)
      4'd7:    r = val << amt;
      4'd8:    r = val >> amt;
      4'd9:    r = $signed(val) >>> amt;
      default: r = val;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] aluOp(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      4'd0:             r = a + b;
      4'd1:             r = a - b;
      4'd2:             r = a & b;
      4'd3:             r = a | b;
      4'd4:             r = {31'd0, $signed(a) < $signed(b)};
      4'd5:             r = a ^ b;
      4'd6:             r = ~(a | b);
      4'd7, 4'd8, 4'd9: r = shiftOp(op, b, sh);
      default:          r = 32'd0;
    endcase
    return r;
  endfunction

  assign isShift   = (bus.iALUctrl == 4'd7) || (bus.iALUctrl == 4'd8) || (bus.iALUctrl == 4'd9);
  assign longStart = (state == IDLE) && bus.iValid && isShift && (bus.iShamt > STEP);
  assign shiftMore = (state == SHIFT) && (rem > STEP);
  assign stepAmt   = (rem > STEP) ? STEP : rem;
  assign accNext   = shiftOp(bus.iALUctrl, acc, stepAmt);
  assign aluRes    = aluOp(bus.iALUctrl, bus.iSrcA, bus.iSrcB, bus.iShamt);
  assign bus.oStall = bus.iMemStall || longStart || shiftMore;

`ifdef EX_OVF_TRAP_EN
  logic [31:0] sum, diff;
  logic        addOvf, subOvf, emOvf, ovfExcM;
  assign sum    = bus.iSrcA + bus.iSrcB;
  assign diff   = bus.iSrcA - bus.iSrcB;
  assign addOvf = (bus.iSrcA[31] == bus.iSrcB[31]) && (sum[31] != bus.iSrcA[31]);
  assign subOvf = (bus.iSrcA[31] != bus.iSrcB[31]) && (diff[31] != bus.iSrcA[31]);
  assign trap   = bus.iValid && !bus.iBranch &&
                  (((bus.iALUctrl == 4'd0) && addOvf) || ((bus.iALUctrl == 4'd1) && subOvf));
`else
  assign trap   = 1'b0;
`endif

  // Branch resolution is combinational so fetch redirects in the same cycle.
  assign brTaken = (bus.iSrcA == bus.iSrcB);
  assign brFire  = bus.iValid && bus.iBranch && !bus.iMemStall && !bus.iFlush;
  assign bus.oBrUpdate   = brFire;
  assign bus.oBrTaken    = brFire && brTaken;
  assign bus.oMispredict = brFire && (brTaken != bus.iPredTaken);
  assign bus.oRedirectPC = brFire ? (brTaken ? bus.iBrTarget : bus.iPCplus4) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (bus.iFlush) begin
      stateNext = IDLE;
    end else if (!bus.iMemStall) begin
      case (state)
        IDLE:    if (longStart) stateNext = SHIFT;
        SHIFT:   if (!shiftMore) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // EX/MEM load: a bubble unless an instruction finishes this cycle.
  always_comb begin
    emLoad     = !bus.iMemStall;
    emValid    = 1'b0;
    emRd       = 5'd0;
    emRegWrite = 1'b0;
    emResult   = 32'd0;
`ifdef EX_OVF_TRAP_EN
    emOvf      = 1'b0;
`endif
    if (!bus.iMemStall && !bus.iFlush) begin
      if (state == IDLE && bus.iValid && !longStart) begin
        emValid    = 1'b1;
        emRd       = bus.iRd;
        emRegWrite = bus.iRegWrite && !bus.iBranch && !trap;
        emResult   = aluRes;
`ifdef EX_OVF_TRAP_EN
        emOvf      = trap;
`endif
      end else if (state == SHIFT && !shiftMore) begin
        emValid    = 1'b1;
        emRd       = bus.iRd;
        emRegWrite = bus.iRegWrite;
        emResult   = accNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 32'd0;
      rem <= 5'd0;
    end else if (bus.iFlush) begin
      rem <= 5'd0;
    end else if (!bus.iMemStall) begin
      if (longStart) begin
        acc <= shiftOp(bus.iALUctrl, bus.iSrcB, STEP);
        rem <= bus.iShamt - STEP;
      end else if (state == SHIFT) begin
        acc <= accNext;
        rem <= rem - stepAmt;
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.oValid_M    <= 1'b0;
      bus.oRd_M       <= 5'd0;
      bus.oRegWrite_M <= 1'b0;
      bus.oResult_M   <= 32'd0;
    end else if (emLoad) begin
      bus.oValid_M    <= emValid;
      bus.oRd_M       <= emRd;
      bus.oRegWrite_M <= emRegWrite;
      bus.oResult_M   <= emResult;
    end
  end

`ifdef EX_OVF_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovfExcM <= 1'b0;
    else if (emLoad) ovfExcM <= emOvf;
  end
  assign bus.oOvfExc = ovfExcM;
`else
  assign bus.oOvfExc = 1'b0;
`endif
endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: expected EX/MEM entries are queued at issue and popped on completion.
module tb_ex_alu_stage;
  logic clk, rst_n;
  ex_alu_stage_if bus();

  ex_alu_stage #(.SHIFT_STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] res;
    logic        ovf;
  } emT;

  emT sbq[$];
  int vectors = 0;
  int fails   = 0;

  function automatic emT obsEm();
    return {bus.oValid_M, bus.oRd_M, bus.oRegWrite_M, bus.oResult_M, bus.oOvfExc};
  endfunction

  function automatic emT model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic rw, input logic [4:0] rd,
                               input logic br);
    emT m;
    logic [31:0] r;
    logic ovf;
    ovf = 1'b0;
    case (c)
      4'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = ~(a | b);
      4'd7: r = b << sh;
      4'd8: r = b >> sh;
      4'd9: r = $signed(b) >>> sh;
      default: r = 32'd0;
    endcase
    if (br) ovf = 1'b0;
    m.v = 1'b1; m.rd = rd; m.res = r;
`ifdef EX_OVF_TRAP_EN
    m.rw = rw && !br && !ovf; m.ovf = ovf;
`else
    m.rw = rw && !br; m.ovf = 1'b0;
`endif
    return m;
  endfunction

  task automatic setIdle();
    bus.iValid = 0; bus.iALUctrl = 0; bus.iSrcA = 0; bus.iSrcB = 0; bus.iShamt = 0;
    bus.iRegWrite = 0; bus.iRd = 0; bus.iBranch = 0; bus.iPredTaken = 0;
    bus.iBrTarget = 0; bus.iPCplus4 = 0; bus.iFlush = 0; bus.iMemStall = 0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic rw, input logic [4:0] rd);
    bus.iValid = 1; bus.iALUctrl = c; bus.iSrcA = a; bus.iSrcB = b; bus.iShamt = sh;
    bus.iRegWrite = rw; bus.iRd = rd; bus.iBranch = 0;
    sbq.push_back(model(c, a, b, sh, rw, rd, 1'b0));
  endtask

  // Drives one instruction, holds it while oStall is high, returns occupancy and stall trace.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd,
                       output int cyc, output logic [15:0] stallSeq);
    logic stallNow;
    drive(c, a, b, sh, 1'b1, rd);
    cyc = 0; stallSeq = '0;
    forever begin
      #2;
      stallNow = bus.oStall;
      if (cyc < 16) stallSeq[cyc] = stallNow;
      cyc++;
      @(posedge clk); #1;
      if (!stallNow || cyc >= 40) break;
    end
    setIdle();
    if (cyc >= 40) begin
      vectors++; fails++;
      $display("FAIL issue_timeout op=%0d stall still %b after %0d cycles", c, bus.oStall, cyc);
    end
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    setIdle(); rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.oStall, bus.oValid_M, bus.oResult_M, bus.oRd_M, bus.oRegWrite_M, bus.oMispredict,
            bus.oRedirectPC, bus.oBrUpdate, bus.oBrTaken, bus.oOvfExc};
    vectors++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_n = 1;
  endtask

  task automatic test_alu();
    logic [3:0]  tc[12] = '{0, 0, 1, 2, 3, 4, 4, 5, 6, 12, 7, 9};
    logic [31:0] ta[12] = '{32'h7FFFFFFF, 32'h12345678, 32'd5, 32'hF0F0F0F0, 32'h0F0F0000,
                            32'hFFFFFFFF, 32'd1, 32'hAAAA5555, 32'd0, 32'h1234, 32'd0, 32'd0};
    logic [31:0] tb[12] = '{32'd1, 32'h11111111, 32'd7, 32'hFF00FF00, 32'h000000F0,
                            32'd1, 32'hFFFFFFFF, 32'hFFFF0000, 32'd0, 32'h5678, 32'd1, 32'hF0000000};
    logic [4:0]  ts[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3};
    emT exp, got;
    int cyc;
    logic [15:0] ss;
    for (int i = 0; i < 18; i++) begin
      logic [3:0] c; logic [31:0] a, b; logic [4:0] sh;
      if (i < 12) begin c = tc[i]; a = ta[i]; b = tb[i]; sh = ts[i]; end
      else begin c = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; sh = 5'($urandom_range(0, 31)); end
      issue(c, a, b, sh, 5'(i + 1), cyc, ss);
      exp = sbq.pop_front(); got = obsEm();
      vectors++;
      if (got !== exp) begin fails++; $display("FAIL alu_%0d op=%0d got=%h want=%h", i, c, got, exp); end
      if (i < 12) begin
        vectors++;
        if (cyc !== 1) begin fails++; $display("FAIL alu_latency_%0d got=%0d want=1", i, cyc); end
      end
    end
  endtask

  task automatic test_shift_long();
    emT exp, got;
    int cyc;
    logic [15:0] ss;
    issue(4'd7, 32'd0, 32'h00000003, 5'd9, 5'd10, cyc, ss);
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp || got.res !== 32'h00000600) begin
      fails++; $display("FAIL sll9 got=%h want=%h", got, exp);
    end
    vectors++;
    if (cyc !== 3 || ss[2:0] !== 3'b011) begin
      fails++; $display("FAIL sll9_stall got cyc=%0d seq=%b want cyc=3 seq=011", cyc, ss[2:0]);
    end
    issue(4'd9, 32'd0, 32'h80000000, 5'd31, 5'd11, cyc, ss);
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp || got.res !== 32'hFFFFFFFF || cyc !== 8) begin
      fails++; $display("FAIL sra31 got=%h cyc=%0d want=%h cyc=8", got, cyc, exp);
    end
    issue(4'd8, 32'd0, 32'hDEADBEEF, 5'd13, 5'd12, cyc, ss);
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp || cyc !== 4) begin
      fails++; $display("FAIL srl13 got=%h cyc=%0d want=%h cyc=4", got, cyc, exp);
    end
  endtask

  task automatic test_branch();
    logic [31:0] bA[2] = '{32'd5, 32'd5};
    logic [31:0] bB[2] = '{32'd5, 32'd6};
    logic [34:0] want, seen;
    emT exp, got;
    for (int i = 0; i < 2; i++) begin
      bus.iValid = 1; bus.iBranch = 1; bus.iALUctrl = 4'd1; bus.iSrcA = bA[i]; bus.iSrcB = bB[i];
      bus.iPredTaken = 0; bus.iBrTarget = 32'h00400100; bus.iPCplus4 = 32'h00400008;
      bus.iRd = 5'd7; bus.iRegWrite = 0;
      sbq.push_back(model(4'd1, bA[i], bB[i], 5'd0, 1'b0, 5'd7, 1'b1));
      want = (i == 0) ? {1'b1, 1'b1, 1'b1, 32'h00400100} : {1'b0, 1'b0, 1'b1, 32'h00400008};
      #2;
      seen = {bus.oMispredict, bus.oBrTaken, bus.oBrUpdate, bus.oRedirectPC};
      vectors++;
      if (seen !== want) begin fails++; $display("FAIL beq_%0d strobes got=%h want=%h", i, seen, want); end
      @(posedge clk); #1;
      setIdle();
      exp = sbq.pop_front(); got = obsEm();
      vectors++;
      if (got !== exp) begin fails++; $display("FAIL beq_%0d exmem got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_memstall();
    emT exp, got, held;
    int cyc, pulses;
    logic [15:0] ss;
    issue(4'd0, 32'd10, 32'd20, 5'd0, 5'd3, cyc, ss);
    held = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== held) begin fails++; $display("FAIL stall_pre got=%h want=%h", got, held); end
    drive(4'd0, 32'd1, 32'd2, 5'd0, 1'b1, 5'd4);
    bus.iMemStall = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (bus.oStall !== 1'b1) begin fails++; $display("FAIL stall_ostall_%0d got=%b want=1", i, bus.oStall); end
      @(posedge clk); #1;
      got = obsEm();
      vectors++;
      if (got !== held) begin fails++; $display("FAIL stall_hold_%0d got=%h want=%h", i, got, held); end
    end
    bus.iMemStall = 0;
    @(posedge clk); #1;
    setIdle();
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp) begin fails++; $display("FAIL stall_release got=%h want=%h", got, exp); end
    bus.iValid = 1; bus.iBranch = 1; bus.iALUctrl = 4'd1; bus.iSrcA = 32'd9; bus.iSrcB = 32'd9;
    bus.iPredTaken = 1; bus.iBrTarget = 32'h1000; bus.iPCplus4 = 32'h2000; bus.iMemStall = 1;
    sbq.push_back(model(4'd1, 32'd9, 32'd9, 5'd0, 1'b0, 5'd0, 1'b1));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.iMemStall = 0;
      if (i == 4) setIdle();
      #2;
      if (bus.oBrUpdate === 1'b1) pulses++;
      @(posedge clk); #1;
      if (i == 2) begin
        got = obsEm();
        vectors++;
        if (got !== exp) begin fails++; $display("FAIL stall_beq_hold got=%h want=%h", got, exp); end
      end
      if (i == 3) begin
        exp = sbq.pop_front(); got = obsEm();
        vectors++;
        if (got !== exp) begin fails++; $display("FAIL stall_beq_exmem got=%h want=%h", got, exp); end
      end
    end
    vectors++;
    if (pulses !== 1) begin fails++; $display("FAIL stall_beq_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_flush();
    emT exp, got;
    int cyc;
    logic [15:0] ss;
    bus.iValid = 1; bus.iALUctrl = 4'd9; bus.iSrcB = 32'h80000000; bus.iShamt = 5'd31;
    bus.iRegWrite = 1; bus.iRd = 5'd20;
    @(posedge clk); #1;
    bus.iFlush = 1;
    @(posedge clk); #1;
    setIdle();
    #1;
    got = obsEm();
    vectors++;
    if (bus.oStall !== 1'b0 || got.v !== 1'b0 || got.rw !== 1'b0) begin
      fails++; $display("FAIL flush_abort got stall=%b v=%b rw=%b want 0 0 0", bus.oStall, got.v, got.rw);
    end
    @(posedge clk); #1;
    issue(4'd0, 32'd100, 32'd23, 5'd0, 5'd21, cyc, ss);
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp || cyc !== 1) begin
      fails++; $display("FAIL flush_next_add got=%h cyc=%0d want=%h cyc=1", got, cyc, exp);
    end
  endtask

  task automatic test_reset_midshift();
    logic [75:0] outs;
    emT exp, got;
    int cyc;
    logic [15:0] ss;
    bus.iValid = 1; bus.iALUctrl = 4'd7; bus.iSrcB = 32'h0000F00D; bus.iShamt = 5'd30;
    bus.iRegWrite = 1; bus.iRd = 5'd9;
    repeat (2) begin @(posedge clk); #1; end
    setIdle(); rst_n = 0;
    #1;
    outs = {bus.oStall, bus.oValid_M, bus.oResult_M, bus.oRd_M, bus.oRegWrite_M, bus.oMispredict,
            bus.oRedirectPC, bus.oBrUpdate, bus.oBrTaken, bus.oOvfExc};
    vectors++;
    if (outs !== '0) begin fails++; $display("FAIL reset_midshift_outputs got=%h want=0", outs); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    issue(4'd7, 32'd0, 32'h0000F00D, 5'd30, 5'd9, cyc, ss);
    exp = sbq.pop_front(); got = obsEm();
    vectors++;
    if (got !== exp || cyc !== 8) begin
      fails++; $display("FAIL reset_midshift_redo got=%h cyc=%0d want=%h cyc=8", got, cyc, exp);
    end
  endtask

  task automatic test_back_to_back();
    emT exp, got;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        exp = sbq.pop_front(); got = obsEm();
        vectors++;
        if (got !== exp) begin fails++; $display("FAIL b2b_%0d got=%h want=%h", i - 1, got, exp); end
      end
      if (i < 5) drive(4'($urandom_range(0, 6)), $urandom, $urandom, 5'd0, 1'b1, 5'(i + 24));
      else setIdle();
      @(posedge clk); #1;
    end
    got = obsEm();
    vectors++;
    if (got.v !== 1'b0) begin fails++; $display("FAIL b2b_bubble got v=%b want 0", got.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    setIdle();
    rst_n = 0;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    test_alu();
    test_shift_long();
    test_branch();
    test_memstall();
    test_flush();
    test_reset_midshift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
